// File: rtl/up_bus_combiner.sv
// up_bus_combiner: combines NUM_SLAVES register-slave responses into one up bus response,
// latency: slave ack at cycle t -> up_rack/up_wack (+ data) at t+1, registered; timeout ack at req+TIMEOUT_CYCLES+1,
// backpressure: none; every request ends in exactly one ack pulse. Optional timeout: define UP_BUS_TIMEOUT_EN.

// Per-direction response tracker: IDLE/WAIT FSM with optional timeout counter.
module up_bus_resp_fsm #(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req,
  input  logic [NUM_SLAVES-1:0] ack,
  output logic                  resp,       // registered ack pulse towards up_axi
  output logic                  done,       // a response is being issued this cycle
  output logic                  timeout,    // this cycle's response is a forced one
  output logic                  stray,      // ack seen with nothing outstanding
  output logic                  multi       // more than one slave acked this cycle
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state;
  logic   any_ack;

`ifdef UP_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  assign any_ack = |ack;
  assign multi   = ($countones(ack) > 1);

  // Decide this cycle's response/timeout/stray events from state and inputs.
  always_comb begin
    done    = 1'b0;
    timeout = 1'b0;
    stray   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A same-cycle ack on a fresh request is a zero-latency slave response.
        if (any_ack && req) begin
          done = 1'b1;
        end else if (any_ack) begin
          stray = 1'b1;
        end
      end
      ST_WAIT: begin
        // Any ack wins over the timeout, even in the final window cycle.
        if (any_ack) begin
          done = 1'b1;
        end
`ifdef UP_BUS_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
`endif
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // FSM state, timeout window counter and registered ack pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      resp  <= 1'b0;
`ifdef UP_BUS_TIMEOUT_EN
      tcnt  <= '0;
`endif
    end else begin
      resp <= done;
      case (state)
        ST_IDLE: begin
          if (req && !any_ack) begin
            state <= ST_WAIT;
`ifdef UP_BUS_TIMEOUT_EN
            tcnt  <= TW'(1);
`endif
          end
        end
        ST_WAIT: begin
          // Requests arriving here are protocol violations and are ignored;
          // the original window keeps running.
          if (done) begin
            state <= ST_IDLE;
`ifdef UP_BUS_TIMEOUT_EN
            tcnt  <= '0;
          end else begin
            tcnt  <= tcnt + TW'(1);
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// Top: independent write and read trackers plus read data mux and sticky diagnostics.
module up_bus_combiner #(
  parameter int          NUM_SLAVES     = 4,
  parameter int          TIMEOUT_CYCLES = 32,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADDEAD
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     up_wreq,
  input  logic                     up_rreq,
  output logic                     up_wack,
  output logic                     up_rack,
  output logic [31:0]              up_rdata,
  input  logic [NUM_SLAVES-1:0]    up_wack_s,
  input  logic [NUM_SLAVES-1:0]    up_rack_s,
  input  logic [32*NUM_SLAVES-1:0] up_rdata_s,
  input  logic                     up_err_clr,
  output logic [15:0]              up_timeout_cnt,
  output logic                     up_collision,
  output logic                     up_stray_ack
);

  logic        wr_done, wr_timeout, wr_stray, wr_multi;
  logic        rd_done, rd_timeout, rd_stray, rd_multi;
  logic [31:0] rdata_or;

  up_bus_resp_fsm #(
    .NUM_SLAVES     (NUM_SLAVES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wr (
    .clk     (up_clk),
    .rstn    (up_rstn),
    .req     (up_wreq),
    .ack     (up_wack_s),
    .resp    (up_wack),
    .done    (wr_done),
    .timeout (wr_timeout),
    .stray   (wr_stray),
    .multi   (wr_multi)
  );

  up_bus_resp_fsm #(
    .NUM_SLAVES     (NUM_SLAVES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd (
    .clk     (up_clk),
    .rstn    (up_rstn),
    .req     (up_rreq),
    .ack     (up_rack_s),
    .resp    (up_rack),
    .done    (rd_done),
    .timeout (rd_timeout),
    .stray   (rd_stray),
    .multi   (rd_multi)
  );

  // OR of every slave's read data; idle slaves are expected to drive zero.
  always_comb begin
    rdata_or = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rdata_or = rdata_or | up_rdata_s[32*k +: 32];
    end
  end

  // Read data is registered alongside up_rack and is zero outside the ack cycle.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      up_rdata <= '0;
    end else if (rd_done) begin
`ifdef UP_BUS_TIMEOUT_EN
      up_rdata <= rd_timeout ? ERROR_DATA : rdata_or;
`else
      up_rdata <= rdata_or;
`endif
    end else begin
      up_rdata <= '0;
    end
  end

  // Sticky collision flag; a new event in the clear cycle keeps it set.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      up_collision <= 1'b0;
    end else if (wr_multi || rd_multi) begin
      up_collision <= 1'b1;
    end else if (up_err_clr) begin
      up_collision <= 1'b0;
    end
  end

  // Sticky stray-ack flag; a new event in the clear cycle keeps it set.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      up_stray_ack <= 1'b0;
    end else if (wr_stray || rd_stray) begin
      up_stray_ack <= 1'b1;
    end else if (up_err_clr) begin
      up_stray_ack <= 1'b0;
    end
  end

`ifdef UP_BUS_TIMEOUT_EN
  logic [1:0]  to_inc;
  logic [16:0] to_sum;

  assign to_inc = {1'b0, wr_timeout} + {1'b0, rd_timeout};
  assign to_sum = {1'b0, up_timeout_cnt} + {15'd0, to_inc};

  // Saturating timeout counter; both directions may time out in one cycle.
  // An increment in the clear cycle is applied to the uncleared value.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      up_timeout_cnt <= '0;
    end else if (to_inc != 2'd0) begin
      up_timeout_cnt <= to_sum[16] ? 16'hFFFF : to_sum[15:0];
    end else if (up_err_clr) begin
      up_timeout_cnt <= '0;
    end
  end
`else
  assign up_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_up_bus_combiner.sv
// Bench for up_bus_combiner: directed scenarios plus randomized traffic against a
// transaction-level reference model (outstanding flag + request timestamp per direction).
module tb_up_bus_combiner;

  localparam int          NS  = 4;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADDEAD;
`ifdef UP_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            up_clk = 1'b0;
  logic            up_rstn = 1'b0;
  logic            up_wreq = 1'b0, up_rreq = 1'b0;
  logic            up_wack, up_rack;
  logic [31:0]     up_rdata;
  logic [NS-1:0]   up_wack_s = '0, up_rack_s = '0;
  logic [32*NS-1:0] up_rdata_s = '0;
  logic            up_err_clr = 1'b0;
  logic [15:0]     up_timeout_cnt;
  logic            up_collision, up_stray_ack;

  up_bus_combiner #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO), .ERROR_DATA(ERR)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .up_wreq(up_wreq), .up_rreq(up_rreq),
    .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
    .up_wack_s(up_wack_s), .up_rack_s(up_rack_s), .up_rdata_s(up_rdata_s),
    .up_err_clr(up_err_clr), .up_timeout_cnt(up_timeout_cnt),
    .up_collision(up_collision), .up_stray_ack(up_stray_ack)
  );

  always #5 up_clk = ~up_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: per direction (0 = write, 1 = read).
  bit          pend [2];
  int unsigned start [2];
  int unsigned cyc = 0;
  logic        exp_wack = 0, exp_rack = 0, exp_coll = 0, exp_stray = 0;
  logic [31:0] exp_rdata = 0;
  int unsigned exp_tcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one cycle using the inputs currently applied.
  task automatic model_step();
    logic [NS-1:0] a;
    logic [31:0]   ordata;
    bit            r, resp, to, set_coll, set_stray;
    int unsigned   nto;
    ordata = 0;
    for (int k = 0; k < NS; k++) ordata |= up_rdata_s[32*k +: 32];
    if (!up_rstn) begin
      pend[0] = 0; pend[1] = 0;
      exp_wack = 0; exp_rack = 0; exp_rdata = 0;
      exp_tcnt = 0; exp_coll = 0; exp_stray = 0;
    end else begin
      nto = 0; set_coll = 0; set_stray = 0;
      for (int d = 0; d < 2; d++) begin
        a = (d == 1) ? up_rack_s : up_wack_s;
        r = (d == 1) ? up_rreq : up_wreq;
        resp = 0; to = 0;
        if (pend[d]) begin
          if (a != 0) begin
            resp = 1; pend[d] = 0;
          end else if (TO_EN && (cyc - start[d] == TO)) begin
            resp = 1; to = 1; pend[d] = 0;
          end
        end else if (r) begin
          if (a != 0) resp = 1;
          else begin pend[d] = 1; start[d] = cyc; end
        end else if (a != 0) begin
          set_stray = 1;
        end
        if ($countones(a) > 1) set_coll = 1;
        if (to) nto++;
        if (d == 0) exp_wack = resp;
        else begin
          exp_rack  = resp;
          exp_rdata = resp ? (to ? ERR : ordata) : 32'h0;
        end
      end
      if (nto > 0) exp_tcnt = (exp_tcnt + nto > 65535) ? 65535 : exp_tcnt + nto;
      else if (up_err_clr) exp_tcnt = 0;
      if (set_coll) exp_coll = 1; else if (up_err_clr) exp_coll = 0;
      if (set_stray) exp_stray = 1; else if (up_err_clr) exp_stray = 0;
    end
    cyc++;
  endtask

  // One clock: update model, take the edge, compare every output after it.
  task automatic tick();
    model_step();
    @(posedge up_clk);
    #1;
    chk("wack", 32'(up_wack), 32'(exp_wack));
    chk("rack", 32'(up_rack), 32'(exp_rack));
    chk("rdata", up_rdata, exp_rdata);
    chk("timeout_cnt", 32'(up_timeout_cnt), exp_tcnt);
    chk("collision", 32'(up_collision), 32'(exp_coll));
    chk("stray_ack", 32'(up_stray_ack), 32'(exp_stray));
  endtask

  task automatic clear_inputs();
    up_wreq = 0; up_rreq = 0; up_wack_s = '0; up_rack_s = '0;
    up_rdata_s = '0; up_err_clr = 0;
  endtask

  initial begin
    // Reset state.
    up_rstn = 0;
    tick(); tick();
    chk("rst_rack", 32'(up_rack), 0);
    chk("rst_rdata", up_rdata, 0);
    chk("rst_tcnt", 32'(up_timeout_cnt), 0);
    up_rstn = 1;
    tick();

    // Single slave read: ack at cycle 1, response at cycle 2 only.
    up_rreq = 1; tick();
    up_rreq = 0; up_rack_s[2] = 1; up_rdata_s[64 +: 32] = 32'h00001234; tick();
    chk("read_rack", 32'(up_rack), 1);
    chk("read_rdata", up_rdata, 32'h00001234);
    clear_inputs(); tick();
    chk("read_rack_end", 32'(up_rack), 0);
    chk("read_rdata_end", up_rdata, 0);

    // Two slaves ack the same read: ORed data and collision, then clear.
    up_rreq = 1; tick();
    up_rreq = 0; up_rack_s = 4'b1001;
    up_rdata_s[0 +: 32] = 32'h0000F000; up_rdata_s[96 +: 32] = 32'h0000000F; tick();
    chk("coll_rdata", up_rdata, 32'h0000F00F);
    chk("coll_flag", 32'(up_collision), 1);
    clear_inputs(); up_err_clr = 1; tick();
    up_err_clr = 0; tick();
    chk("coll_cleared", 32'(up_collision), 0);

    // Zero-latency read and write in the same cycle.
    up_rreq = 1; up_wreq = 1; up_rack_s[1] = 1; up_wack_s[3] = 1;
    up_rdata_s[32 +: 32] = 32'hA5A50001; tick();
    chk("zl_wack", 32'(up_wack), 1);
    chk("zl_rack", 32'(up_rack), 1);
    chk("zl_rdata", up_rdata, 32'hA5A50001);
    clear_inputs(); tick();

    // Stray read ack with both FSMs idle.
    up_rack_s[1] = 1; tick();
    chk("stray_norack", 32'(up_rack), 0);
    chk("stray_flag", 32'(up_stray_ack), 1);
    clear_inputs(); up_err_clr = 1; tick();
    clear_inputs(); tick();

    // Reset while a read is pending: later ack is stray, no rack.
    up_rreq = 1; tick();
    up_rreq = 0; tick();
    up_rstn = 0; tick();
    up_rstn = 1; tick();
    up_rack_s[0] = 1; up_rdata_s[0 +: 32] = 32'h77; tick();
    chk("rstmid_norack", 32'(up_rack), 0);
    chk("rstmid_stray", 32'(up_stray_ack), 1);
    clear_inputs(); up_err_clr = 1; tick();
    clear_inputs(); tick();

    if (TO_EN) begin
      // Write timeout: forced wack at cycle TO+1.
      up_wreq = 1; tick();
      up_wreq = 0;
      repeat (TO - 1) tick();
      chk("wto_early", 32'(up_wack), 0);
      tick();
      chk("wto_wack", 32'(up_wack), 1);
      chk("wto_cnt", 32'(up_timeout_cnt), 1);
      // Read timeout: error data.
      up_rreq = 1; tick();
      up_rreq = 0;
      repeat (TO) tick();
      chk("rto_rack", 32'(up_rack), 1);
      chk("rto_rdata", up_rdata, ERR);
      chk("rto_cnt", 32'(up_timeout_cnt), 2);
      // Late ack after the timeout fired is stray.
      up_rack_s[2] = 1; tick();
      chk("late_stray", 32'(up_stray_ack), 1);
      chk("late_norack", 32'(up_rack), 0);
      clear_inputs(); tick();
      // Ack on the last window cycle is still a normal response.
      up_rreq = 1; tick();
      up_rreq = 0;
      repeat (TO - 1) tick();
      up_rack_s[3] = 1; up_rdata_s[96 +: 32] = 32'h0BAD0000; tick();
      chk("edge_rdata", up_rdata, 32'h0BAD0000);
      chk("edge_cnt", 32'(up_timeout_cnt), 2);
      clear_inputs(); tick();
    end else begin
      // No timeout: a read waits 200 cycles for its ack.
      up_rreq = 1; tick();
      up_rreq = 0;
      repeat (199) tick();
      up_rack_s[1] = 1; up_rdata_s[32 +: 32] = 32'h00C0FFEE; tick();
      chk("long_rack", 32'(up_rack), 1);
      chk("long_rdata", up_rdata, 32'h00C0FFEE);
      chk("long_cnt", 32'(up_timeout_cnt), 0);
      clear_inputs(); tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      up_rstn    = ($urandom_range(0, 199) != 0);
      up_wreq    = ($urandom_range(0, 5) == 0);
      up_rreq    = ($urandom_range(0, 5) == 0);
      up_err_clr = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < NS; k++) begin
        up_wack_s[k] = ($urandom_range(0, 13) == 0);
        up_rack_s[k] = ($urandom_range(0, 13) == 0);
        up_rdata_s[32*k +: 32] = $urandom();
      end
      tick();
    end
    clear_inputs(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_bus_combiner.md
# up_bus_combiner

Parametrised response combiner for the internal up register bus, replacing the hand-written per-core OR of slave `up_rdata`/`up_rack`/`up_wack` in ADC/DAC top levels. It sits between `up_axi` and NUM_SLAVES register slaves (channels, `up_adc_common`, `up_delay_cntrl`, …), which continue to receive the request bus directly. It adds response tracking, a bus timeout that always terminates a transaction, and collision and stray-ack diagnostics.

## Interface
- NUM_SLAVES, 4: number of slave response ports, 1..16.
- TIMEOUT_CYCLES, 32: cycles a request waits for a slave ack before a forced response; 2..65535.
- ERROR_DATA, 32'hDEADDEAD: `up_rdata` value returned on a read timeout.

Ports:
- up_clk  in  1  sole clock.
- up_rstn  in  1  reset, synchronous, active-low.
- up_wreq  in  1  write request pulse from `up_axi`.
- up_rreq  in  1  read request pulse from `up_axi`.
- up_wack  out  1  write acknowledge to `up_axi`, one-cycle pulse.
- up_rack  out  1  read acknowledge to `up_axi`, one-cycle pulse.
- up_rdata  out  32  read data, valid only while `up_rack` = 1, otherwise 0.
- up_wack_s  in  NUM_SLAVES  per-slave write acks.
- up_rack_s  in  NUM_SLAVES  per-slave read acks.
- up_rdata_s  in  32*NUM_SLAVES  per-slave read data; slave k occupies bits [32k+31:32k].
- up_err_clr  in  1  clears all diagnostics.
- up_timeout_cnt  out  16  saturating count of timed-out transactions, reads and writes combined.
- up_collision  out  1  sticky: two or more acks in the same direction in one cycle.
- up_stray_ack  out  1  sticky: an ack arrived with no transaction outstanding in that direction.

## Operation
- Read and write paths are independent, identical FSMs with states IDLE and WAIT, plus a counter `tcnt` of width $clog2(TIMEOUT_CYCLES+1).
- IDLE, request seen, no ack in the same cycle: go to WAIT and set `tcnt` = 1.
- IDLE, request seen with an ack in the same cycle: the ack counts as the response (zero-latency slave). Issue the response; stay in IDLE.
- IDLE, ack seen without a request: set `up_stray_ack`; no response is issued.
- WAIT, any ack bit set: issue the response and go to IDLE.
- WAIT, no ack, `tcnt` = TIMEOUT_CYCLES: issue a forced response. Read data = ERROR_DATA. Increment `up_timeout_cnt`, saturating at 16'hFFFF. Go to IDLE.
- WAIT, otherwise: `tcnt` += 1.
- WAIT, new request in the same direction: a protocol violation. The request is ignored and the original timeout window continues.
- Read data on a normal response = bitwise OR of `up_rdata_s` over all slaves, sampled in the ack cycle.
- More than one ack bit in a cycle: data is still ORed, the response is still issued, and `up_collision` is set.
- An ack arriving after a timeout has already fired: treated as stray.
- `up_err_clr`: clears `up_timeout_cnt`, `up_collision` and `up_stray_ack` on the next edge. If clear and set happen in the same cycle, set wins.

## Timing
- Reset (up_rstn = 0 at a rising edge): both FSMs go to IDLE, `tcnt` = 0, and all outputs = 0. A pending transaction is dropped with no ack; acks arriving after reset release are stray.
- Response latency: slave ack at cycle t gives `up_rack`/`up_wack` plus data at t+1, always registered. There is no combinational path from inputs to outputs.
- Timeout latency: request at cycle 0 with no ack in cycles 0..TIMEOUT_CYCLES gives the forced ack at cycle TIMEOUT_CYCLES+1.
- Read and write responses may coincide in the same cycle.
- Diagnostic outputs update one cycle after the triggering event.

## Configuration
- UP_BUS_TIMEOUT_EN defined: timeout logic as specified above.
- UP_BUS_TIMEOUT_EN undefined:
  - WAIT holds until an ack arrives, however long that takes.
  - `tcnt` is not instantiated and `up_timeout_cnt` is tied to 0.
  - ERROR_DATA and TIMEOUT_CYCLES are unused.
  - All other behaviour is unchanged.

## Test plan
- NUM_SLAVES=4. `up_rreq` at cycle 0; slave 2 asserts rack at cycle 1 with rdata 32'h00001234, all other rdata = 0 → `up_rack` = 1 at cycle 2 with `up_rdata` = 32'h00001234, and 0 at cycle 3.
- Slaves 0 and 3 ack the same read, with data 32'h0000F000 and 32'h0000000F → `up_rdata` = 32'h0000F00F and `up_collision` = 1. Then `up_err_clr` → `up_collision` = 0.
- UP_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8. Write request at cycle 0, no ack → `up_wack` at cycle 9 and `up_timeout_cnt` = 1. A read likewise times out → `up_rdata` = 32'hDEADDEAD and `up_timeout_cnt` = 2.
- `up_rack_s[1]` pulsed with both FSMs IDLE → no `up_rack`; `up_stray_ack` = 1 at the next cycle.
- Read request, then `up_rstn` low at cycle 2, released at cycle 3, then slave acks at cycle 4 → no `up_rack` ever; `up_stray_ack` = 1.
- UP_BUS_TIMEOUT_EN undefined. Read request, slave acks at cycle 200 → `up_rack` at cycle 201 and `up_timeout_cnt` stays 0.
